// File: rtl/rns_mod_accum.sv
// Frame accumulator in the residue system modulo 2^16-1: sums a frame of 16-bit
// residues with end-around carry and presents the normalised sum, word count and overflow.
module rns_mod_accum #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             flush,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Modulo-(2^16-1) adder: the carry out of bit 15 re-enters at bit 0. When a
    // carry occurs the low half is at most 0xFFFE, so the second add cannot carry.
    function automatic logic [15:0] mod_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // 0xFFFF is the second encoding of residue zero.
    function automatic logic [15:0] mod_norm(input logic [15:0] x);
        return (x == 16'hFFFF) ? 16'h0000 : x;
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept_s;
    logic             cnt_sat_s;
    logic [15:0]      sum_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // Datapath terms shared by every accepting transition.
    always_comb begin
        accept_s  = in_valid & in_ready_q;
        cnt_sat_s = (cnt_q == CNT_MAX);
        sum_s     = mod_add(acc_q, in_data);
        if (cnt_sat_s) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_ONE;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    acc_d   = 16'h0000;
                    cnt_d   = CNT_ZERO;
                    ovf_d   = 1'b0;
                end else if (accept_s) begin
                    acc_d = sum_s;
                    cnt_d = cnt_inc_s;
                    ovf_d = ovf_q | cnt_sat_s;
                    if (in_last) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_sum_d   = mod_norm(sum_s);
                        out_count_d = cnt_inc_s;
                        out_ovf_d   = ovf_q | cnt_sat_s;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                // flush is deliberately ignored here so a presented result is never lost
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    acc_d       = 16'h0000;
                    cnt_d       = CNT_ZERO;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                acc_d       = 16'h0000;
                cnt_d       = CNT_ZERO;
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d != ST_HOLD);
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= 16'h0000;
            cnt_q       <= CNT_ZERO;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= 16'h0000;
            out_count_q <= CNT_ZERO;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_rns_mod_accum.sv
// Self-checking bench: two instances (CNT_W=8 and CNT_W=2) share stimulus and are
// compared against a frame-level arithmetic model of the modulo-65535 sum.
module tb_rns_mod_accum;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        flush;
    logic        out_ready;

    logic        in_ready_a, out_ovf_a, out_valid_a;
    logic [15:0] out_sum_a;
    logic [7:0]  out_count_a;
    logic        in_ready_b, out_ovf_b, out_valid_b;
    logic [15:0] out_sum_b;
    logic [1:0]  out_count_b;

    int total;
    int bad;
    logic [15:0] frame_q[$];

    rns_mod_accum #(.CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_a), .flush(flush), .out_sum(out_sum_a), .out_count(out_count_a),
        .out_ovf(out_ovf_a), .out_valid(out_valid_a), .out_ready(out_ready)
    );

    rns_mod_accum #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_b), .flush(flush), .out_sum(out_sum_b), .out_count(out_count_b),
        .out_ovf(out_ovf_b), .out_valid(out_valid_b), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Residue sum of the whole frame: plain integer sum reduced modulo 65535.
    function automatic logic [15:0] model_sum();
        longint a;
        a = 0;
        foreach (frame_q[i]) a += longint'(frame_q[i]);
        return 16'(a % 65535);
    endfunction

    task automatic drive_frame(input bit gaps);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 16'(($urandom));
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 16'h0;
        repeat (2) @(posedge clk);
        #3;
        total++;
        if ({in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_sum_a, out_count_a, out_ovf_a}
            !== {4'b0000, 16'h0000, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: rdy=%b%b vld=%b%b sum=%h cnt=%0d ovf=%b want all zero",
                     in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_sum_a, out_count_a, out_ovf_a);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready_a !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready_a);
        end
        @(posedge clk); #1;
        total++;
        if ({in_ready_a, in_ready_b} !== 2'b11) begin
            bad++;
            $display("FAIL ready_after_reset: got %b%b want 11", in_ready_a, in_ready_b);
        end
    endtask

    task automatic test_directed();
        logic [15:0] exp_sum;
        logic [7:0]  exp_cnt;
        for (int c = 0; c < 4; c++) begin
            frame_q.delete();
            case (c)
                0: begin frame_q.push_back(16'h0001); frame_q.push_back(16'h0002); frame_q.push_back(16'h0003); exp_sum = 16'h0006; exp_cnt = 8'd3; end
                1: begin frame_q.push_back(16'hFFFE); frame_q.push_back(16'h0003); exp_sum = 16'h0002; exp_cnt = 8'd2; end
                2: begin frame_q.push_back(16'h8000); frame_q.push_back(16'h7FFF); exp_sum = 16'h0000; exp_cnt = 8'd2; end
                default: begin frame_q.push_back(16'hFFFF); exp_sum = 16'h0000; exp_cnt = 8'd1; end
            endcase
            drive_frame(1'b0);
            total++;
            if ({out_valid_a, out_sum_a, out_count_a, out_ovf_a, in_ready_a} !== {1'b1, exp_sum, exp_cnt, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL directed_%0d: got v=%b sum=%h cnt=%0d ovf=%b rdy=%b want v=1 sum=%h cnt=%0d ovf=0 rdy=0",
                         c, out_valid_a, out_sum_a, out_count_a, out_ovf_a, in_ready_a, exp_sum, exp_cnt);
            end
            total++;
            if ({out_valid_b, out_sum_b, out_count_b, out_ovf_b} !== {1'b1, exp_sum, exp_cnt[1:0], 1'b0}) begin
                bad++;
                $display("FAIL directed_b_%0d: got v=%b sum=%h cnt=%0d ovf=%b want v=1 sum=%h cnt=%0d ovf=0",
                         c, out_valid_b, out_sum_b, out_count_b, out_ovf_b, exp_sum, exp_cnt[1:0]);
            end
            release_result();
            total++;
            if ({out_valid_a, in_ready_a, out_valid_b, in_ready_b} !== 4'b0101) begin
                bad++;
                $display("FAIL directed_release_%0d: got v/rdy=%b%b %b%b want 01 01",
                         c, out_valid_a, in_ready_a, out_valid_b, in_ready_b);
            end
        end
    endtask

    task automatic test_backpressure();
        frame_q.delete();
        frame_q.push_back(16'h0010);
        frame_q.push_back(16'h0020);
        drive_frame(1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = 16'(($urandom));
            flush    = i[0];
            @(posedge clk); #1;
            total++;
            if ({out_valid_a, out_sum_a, out_count_a, out_ovf_a, in_ready_a} !== {1'b1, 16'h0030, 8'd2, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_stable_%0d: got v=%b sum=%h cnt=%0d ovf=%b rdy=%b want v=1 sum=0030 cnt=2 ovf=0 rdy=0",
                         i, out_valid_a, out_sum_a, out_count_a, out_ovf_a, in_ready_a);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
        out_ready = 1'b1;
        #1;
        total++;
        if ({out_valid_a, out_sum_a} !== {1'b1, 16'h0030}) begin
            bad++;
            $display("FAIL hold_deliver: got v=%b sum=%h want v=1 sum=0030", out_valid_a, out_sum_a);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid_a, in_ready_a} !== 2'b01) begin
            bad++;
            $display("FAIL hold_release: got v=%b rdy=%b want v=0 rdy=1", out_valid_a, in_ready_a);
        end
    endtask

    task automatic test_overflow_flush();
        frame_q.delete();
        for (int i = 1; i <= 5; i++) frame_q.push_back(16'(i));
        drive_frame(1'b0);
        total++;
        if ({out_valid_b, out_sum_b, out_count_b, out_ovf_b} !== {1'b1, 16'h000F, 2'd3, 1'b1}) begin
            bad++;
            $display("FAIL ovf_b: got v=%b sum=%h cnt=%0d ovf=%b want v=1 sum=000f cnt=3 ovf=1",
                     out_valid_b, out_sum_b, out_count_b, out_ovf_b);
        end
        total++;
        if ({out_count_a, out_ovf_a} !== {8'd5, 1'b0}) begin
            bad++;
            $display("FAIL ovf_a: got cnt=%0d ovf=%b want cnt=5 ovf=0", out_count_a, out_ovf_a);
        end
        release_result();
        frame_q.delete();
        frame_q.push_back(16'h0100);
        frame_q.push_back(16'h0200);
        frame_q.push_back(16'h0300);
        in_valid = 1'b1; in_last = 1'b0; in_data = 16'h0100;
        @(posedge clk); #1;
        in_data = 16'h0200;
        @(posedge clk); #1;
        // last-flagged word offered alongside flush must be discarded
        in_data = 16'h7777; in_last = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
        total++;
        if ({out_valid_a, in_ready_a, out_valid_b} !== 3'b010) begin
            bad++;
            $display("FAIL flush_discard: got v=%b rdy=%b vb=%b want v=0 rdy=1 vb=0", out_valid_a, in_ready_a, out_valid_b);
        end
        frame_q.delete();
        frame_q.push_back(16'h0004);
        drive_frame(1'b0);
        total++;
        if ({out_valid_b, out_sum_b, out_count_b, out_ovf_b} !== {1'b1, 16'h0004, 2'd1, 1'b0}) begin
            bad++;
            $display("FAIL after_flush: got v=%b sum=%h cnt=%0d ovf=%b want v=1 sum=0004 cnt=1 ovf=0",
                     out_valid_b, out_sum_b, out_count_b, out_ovf_b);
        end
        release_result();
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 2; c++) begin
            frame_q.delete();
            frame_q.push_back(16'h1111);
            frame_q.push_back(16'h2222);
            if (c == 0) begin
                in_valid = 1'b1; in_last = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    in_data = frame_q[i];
                    @(posedge clk); #1;
                end
            end else begin
                drive_frame(1'b0);
                total++;
                if ({out_valid_a, out_sum_a} !== {1'b1, 16'h3333}) begin
                    bad++;
                    $display("FAIL pre_reset_hold: got v=%b sum=%h want v=1 sum=3333", out_valid_a, out_sum_a);
                end
            end
            in_valid = 1'b0;
            #2;
            rst = 1'b1;
            #1;
            total++;
            if ({out_valid_a, out_sum_a, out_count_a, out_ovf_a, in_ready_a, out_valid_b, out_count_b}
                !== {1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
                bad++;
                $display("FAIL async_reset_%0d: got v=%b sum=%h cnt=%0d ovf=%b rdy=%b want all zero",
                         c, out_valid_a, out_sum_a, out_count_a, out_ovf_a, in_ready_a);
            end
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk); #1;
            frame_q.delete();
            frame_q.push_back(c == 0 ? 16'h0009 : 16'h0003);
            drive_frame(1'b0);
            total++;
            if ({out_valid_a, out_sum_a, out_count_a} !== {1'b1, frame_q[0], 8'd1}) begin
                bad++;
                $display("FAIL post_reset_%0d: got v=%b sum=%h cnt=%0d want v=1 sum=%h cnt=1",
                         c, out_valid_a, out_sum_a, out_count_a, frame_q[0]);
            end
            release_result();
        end
    endtask

    task automatic test_random();
        int n;
        logic [15:0] es;
        logic [7:0]  ec_a;
        logic [1:0]  ec_b;
        logic        eo_a, eo_b;
        for (int f = 0; f < 25; f++) begin
            n = (f == 24) ? 260 : int'($urandom_range(1, 8));
            frame_q.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) frame_q.push_back(16'hFFFF);
                else                           frame_q.push_back(16'($urandom_range(0, 65535)));
            end
            es   = model_sum();
            ec_a = (n > 255) ? 8'd255 : 8'(n);
            eo_a = (n > 255);
            ec_b = (n > 3) ? 2'd3 : 2'(n);
            eo_b = (n > 3);
            drive_frame(1'b1);
            total++;
            if ({out_valid_a, out_sum_a, out_count_a, out_ovf_a} !== {1'b1, es, ec_a, eo_a}) begin
                bad++;
                $display("FAIL rand_a_%0d: got v=%b sum=%h cnt=%0d ovf=%b want v=1 sum=%h cnt=%0d ovf=%b",
                         f, out_valid_a, out_sum_a, out_count_a, out_ovf_a, es, ec_a, eo_a);
            end
            total++;
            if ({out_valid_b, out_sum_b, out_count_b, out_ovf_b} !== {1'b1, es, ec_b, eo_b}) begin
                bad++;
                $display("FAIL rand_b_%0d: got v=%b sum=%h cnt=%0d ovf=%b want v=1 sum=%h cnt=%0d ovf=%b",
                         f, out_valid_b, out_sum_b, out_count_b, out_ovf_b, es, ec_b, eo_b);
            end
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                in_valid = 1'($urandom);
                flush    = 1'($urandom);
                in_data  = 16'($urandom);
                @(posedge clk); #1;
                total++;
                if ({out_valid_a, out_sum_a, out_count_a, in_ready_a} !== {1'b1, es, ec_a, 1'b0}) begin
                    bad++;
                    $display("FAIL rand_hold_%0d: got v=%b sum=%h cnt=%0d rdy=%b want v=1 sum=%h cnt=%0d rdy=0",
                             f, out_valid_a, out_sum_a, out_count_a, in_ready_a, es, ec_a);
                end
            end
            in_valid = 1'b0; flush = 1'b0;
            release_result();
            total++;
            if ({out_valid_a, in_ready_a} !== 2'b01) begin
                bad++;
                $display("FAIL rand_release_%0d: got v=%b rdy=%b want v=0 rdy=1", f, out_valid_a, in_ready_a);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_overflow_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
